// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM capture block.
// State encoding, default width and the count-to-generator-encoding helper.
package pwm_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // The generator encodes a span of n cycles as n-1.
    function automatic logic [31:0] to_enc(input logic [31:0] n);
        return n - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_edge_det.sv
// Sample stage and edge detection for the captured PWM waveform.
// Define PWM_CAPTURE_SYNC_EN to add a two-flop synchronizer ahead of the sample.
module pwm_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic pwm,
    output logic s,
    output logic rise,
    output logic fall
);

    logic din;
    logic prev;

`ifdef PWM_CAPTURE_SYNC_EN
    logic [1:0] sync;

    // Two-flop synchronizer for an asynchronous pwm source.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], pwm};
        end
    end

    assign din = sync[1];
`else
    assign din = pwm;
`endif

    // Sample register and its one-cycle delayed copy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s    <= 1'b0;
            prev <= 1'b0;
        end else begin
            s    <= din;
            prev <= s;
        end
    end

    assign rise = s & ~prev;
    assign fall = ~s & prev;

endmodule

// File: rtl/pwm_capture.sv
// Recovers period and duty of a PWM waveform in the generator's own encoding.
// Optional build macro: PWM_CAPTURE_SYNC_EN (input synchronizer in pwm_edge_det).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_en,
    input  logic         io_pwm,
    output logic [W-1:0] io_T,
    output logic [W-1:0] io_duty,
    output logic         io_valid,
    output logic         io_stuck,
    output logic         io_level
);

    localparam int          CMAX    = (1 << W) + 1;
    localparam logic [W:0]  CNT_MAX = CMAX[W:0];
    localparam logic [W:0]  CNT_ONE = {{W{1'b0}}, 1'b1};

    state_t         state, state_n;
    logic [W:0]     cnt, cnt_n, cnt_inc;
    logic [W-1:0]   lat, lat_n;
    logic [W-1:0]   t_n, duty_n;
    logic           valid_n, stuck_n;
    logic           s, rise, fall, timeout;

    pwm_edge_det u_edge (
        .clock (clock),
        .reset (reset),
        .pwm   (io_pwm),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    assign io_level = s;
    assign timeout  = (cnt == CNT_MAX);
    assign cnt_inc  = timeout ? cnt : cnt + 1'b1;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter and result updates; an edge beats a timeout.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lat_n   = lat;
        t_n     = io_T;
        duty_n  = io_duty;
        valid_n = 1'b0;
        stuck_n = io_stuck;
        if (!io_en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt_n   = CNT_ONE;
                        stuck_n = 1'b0;
                        state_n = HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lat_n   = W'(to_enc(32'(cnt)));
                        cnt_n   = cnt_inc;
                        state_n = LOW;
                    end else if (timeout) begin
                        cnt_n   = '0;
                        stuck_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        t_n     = W'(to_enc(32'(cnt)));
                        duty_n  = lat;
                        valid_n = 1'b1;
                        stuck_n = 1'b0;
                        cnt_n   = CNT_ONE;
                        state_n = HIGH;
                    end else if (timeout) begin
                        cnt_n   = '0;
                        stuck_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Counter, latched duty and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt      <= '0;
            lat      <= '0;
            io_T     <= '0;
            io_duty  <= '0;
            io_valid <= 1'b0;
            io_stuck <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            lat      <= lat_n;
            io_T     <= t_n;
            io_duty  <= duty_n;
            io_valid <= valid_n;
            io_stuck <= stuck_n;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of generator settings plus
// hand-written sequences for timeout, duty change, reset and enable.
module tb_pwm_capture;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       io_en = 1'b1;
    logic       io_pwm = 1'b0;
    logic [7:0] io_T, io_duty;
    logic       io_valid, io_stuck, io_level;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    logic prev_v = 1'b0;

    typedef struct {
        int t;
        int duty;
        int n;
        int exp_valid;
        int exp_t;
        int exp_duty;
    } vec_t;

    vec_t vecs[6];

    pwm_capture dut (
        .clock    (clock),
        .reset    (reset),
        .io_en    (io_en),
        .io_pwm   (io_pwm),
        .io_T     (io_T),
        .io_duty  (io_duty),
        .io_valid (io_valid),
        .io_stuck (io_stuck),
        .io_level (io_level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Watch every valid pulse for the output invariants.
    always @(negedge clock) begin
        if (io_valid) begin
            valid_cnt++;
            chk("duty_le_T", int'(io_duty <= io_T), 1);
            chk("no_back_to_back", int'(prev_v), 0);
        end
        prev_v = io_valid;
    end

    task automatic drive_cycle(input logic v);
        io_pwm = v;
        @(posedge clock);
        #1;
    endtask

    task automatic gen(input int t, input int d, input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c <= t; c++)
                drive_cycle(c <= d);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        drive_cycle(1'b0);
        chk({tag, "_rst_T"}, int'(io_T), 0);
        chk({tag, "_rst_duty"}, int'(io_duty), 0);
        chk({tag, "_rst_valid"}, int'(io_valid), 0);
        chk({tag, "_rst_stuck"}, int'(io_stuck), 0);
        chk({tag, "_rst_level"}, int'(io_level), 0);
        reset = 1'b1;
        valid_cnt = 0;
    endtask

    initial begin
        int first_seen;
        int base;

        vecs[0] = '{t: 9,   duty: 3, n: 5, exp_valid: 4, exp_t: 9,   exp_duty: 3};
        vecs[1] = '{t: 255, duty: 0, n: 3, exp_valid: 2, exp_t: 255, exp_duty: 0};
        vecs[2] = '{t: 4,   duty: 1, n: 4, exp_valid: 3, exp_t: 4,   exp_duty: 1};
        vecs[3] = '{t: 1,   duty: 0, n: 6, exp_valid: 5, exp_t: 1,   exp_duty: 0};
        vecs[4] = '{t: 7,   duty: 6, n: 4, exp_valid: 3, exp_t: 7,   exp_duty: 6};
        vecs[5] = '{t: 9,   duty: 8, n: 3, exp_valid: 2, exp_t: 9,   exp_duty: 8};

        drive_cycle(1'b0);

        for (int i = 0; i < 6; i++) begin
            do_reset($sformatf("v%0d", i));
            gen(vecs[i].t, vecs[i].duty, 1);
            chk($sformatf("v%0d_first_period", i), valid_cnt, 0);
            gen(vecs[i].t, vecs[i].duty, vecs[i].n - 1);
            drive_cycle(1'b0);
            drive_cycle(1'b0);
            chk($sformatf("v%0d_valids", i), valid_cnt, vecs[i].exp_valid);
            chk($sformatf("v%0d_T", i), int'(io_T), vecs[i].exp_t);
            chk($sformatf("v%0d_duty", i), int'(io_duty), vecs[i].exp_duty);
            chk($sformatf("v%0d_stuck", i), int'(io_stuck), 0);
        end

        // Stuck high, then recovery with a new waveform.
        do_reset("stk");
        gen(9, 3, 2);
        first_seen = -1;
        for (int i = 0; i < 300; i++) begin
            drive_cycle(1'b1);
            if (io_stuck && first_seen < 0)
                first_seen = i;
        end
        chk("stk_latency", int'(first_seen >= 250 && first_seen <= 262), 1);
        chk("stk_stuck", int'(io_stuck), 1);
        chk("stk_level", int'(io_level), 1);
        chk("stk_T_held", int'(io_T), 9);
        chk("stk_duty_held", int'(io_duty), 3);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0);
        chk("stk_before_rise", int'(io_stuck), 1);
        base = valid_cnt;
        gen(4, 1, 1);
        chk("stk_cleared", int'(io_stuck), 0);
        gen(4, 1, 2);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        chk("stk_resume_valids", valid_cnt - base, 2);
        chk("stk_resume_T", int'(io_T), 4);
        chk("stk_resume_duty", int'(io_duty), 1);

        // Duty change mid-stream.
        do_reset("chg");
        gen(9, 3, 3);
        gen(9, 6, 3);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        chk("chg_valids", valid_cnt, 5);
        chk("chg_T", int'(io_T), 9);
        chk("chg_duty", int'(io_duty), 6);

        // Reset pulse while in the low phase.
        do_reset("mid");
        gen(9, 3, 2);
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        do_reset("midp");
        gen(9, 3, 1);
        chk("mid_no_early_valid", valid_cnt, 0);
        gen(9, 3, 2);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        chk("mid_valids", valid_cnt, 2);
        chk("mid_T", int'(io_T), 9);
        chk("mid_duty", int'(io_duty), 3);

        // Enable held low for two running periods.
        do_reset("en");
        gen(9, 3, 2);
        base = valid_cnt;
        io_en = 1'b0;
        gen(9, 3, 2);
        chk("en_off_valids", valid_cnt - base, 0);
        chk("en_off_T", int'(io_T), 9);
        chk("en_off_duty", int'(io_duty), 3);
        io_en = 1'b1;
        base = valid_cnt;
        gen(4, 1, 1);
        chk("en_first_period", valid_cnt - base, 0);
        gen(4, 1, 2);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        chk("en_valids", valid_cnt - base, 2);
        chk("en_T", int'(io_T), 4);
        chk("en_duty", int'(io_duty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
